music_player_ctrl: RTL

MUSIC_PLAYER_CTRL -- requirements
Module: music_player_ctrl

---
 rtl/music_player_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/music_player_ctrl.sv
// Music player sequencer: walks one 128-entry song window of note words,
// holding each note for BEAT_CYCLES cycles after the cycle it was fetched.
module music_player_ctrl #(
  parameter int unsigned BEAT_CYCLES = 6250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play,
  input  logic        stop,
  input  logic [4:0]  song_sel,
  output logic        memreq_val,
  output logic [15:0] memreq_addr,
  input  logic [31:0] memresp_data,
  output logic [2:0]  note,
  output logic        playing,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_END
  } state_e;

  localparam logic [23:0] BEAT_LAST  = 24'(BEAT_CYCLES - 1);
  localparam logic [15:0] SONG_BYTES = 16'h0200;
  localparam logic [31:0] SONG_END   = 32'hFFFF_FFFF;

  // Words 0..7 are note codes; anything else that is not the end marker is a rest.
  function automatic logic [2:0] decode_note(input logic [31:0] d);
    decode_note = (d <= 32'd7) ? d[2:0] : 3'd0;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [15:0] addr_q, addr_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  note_q, note_d;

  logic [15:0] addr_next;
  logic [15:0] window_end;
  logic [15:0] song_base;

  assign addr_next  = addr_q + 16'd4;
  assign window_end = base_q + SONG_BYTES;
  assign song_base  = {2'b00, song_sel, 9'd0};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    note_d  = note_q;

    if (stop) begin
      state_d = S_IDLE;
      note_d  = 3'd0;
      cnt_d   = 24'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (play) begin
            base_d  = song_base;
            addr_d  = song_base;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (memresp_data == SONG_END) begin
            state_d = S_END;
          end else begin
            note_d  = decode_note(memresp_data);
            cnt_d   = BEAT_LAST;
            state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (cnt_q == 24'd0) begin
            // The last entry of the window ends the song rather than spilling over.
            if (addr_next == window_end) begin
              state_d = S_END;
            end else begin
              addr_d  = addr_next;
              state_d = S_FETCH;
            end
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        S_END: begin
          note_d  = 3'd0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= 16'd0;
      addr_q  <= 16'd0;
      cnt_q   <= 24'd0;
      note_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      note_q  <= note_d;
    end
  end

  assign memreq_val  = (state_q == S_FETCH);
  assign memreq_addr = (state_q == S_FETCH) ? addr_q : 16'd0;
  assign note        = note_q;
  assign playing     = (state_q == S_FETCH) || (state_q == S_HOLD);
  assign done        = (state_q == S_END);

endmodule
